// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the frame-update FSM encoding.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic SYNC_ACTIVE = 1'b0;

    // Encoding 2'd3 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } upd_state_e;

endpackage

// File: rtl/vga_frame_controller_if.sv
// Bundle between the horizontal counter / game logic and the frame controller.
interface vga_frame_controller_if;

    logic [15:0] H_Count_Value;
    logic        enable_V_Counter;
    logic        update_ack;
    logic        overrun_clr;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_start;
    logic        update_req;
    logic        overrun;
    logic [15:0] frame_count;

    modport master (
        output H_Count_Value, enable_V_Counter, update_ack, overrun_clr,
        input  hsync, vsync, video_on, pixel_x, pixel_y, frame_start,
               update_req, overrun, frame_count
    );

    modport slave (
        input  H_Count_Value, enable_V_Counter, update_ack, overrun_clr,
        output hsync, vsync, video_on, pixel_x, pixel_y, frame_start,
               update_req, overrun, frame_count
    );

endinterface

// File: rtl/vga_vertical_counter.sv
// Line counter for the 525-line frame plus vertical-blanking and wrap decodes.
module vga_vertical_counter
    import vga_timing_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    output logic [9:0] v_count_o,
    output logic       vbl_start_o,
    output logic       vbl_end_o,
    output logic       frame_wrap_o
);

    logic [9:0] v_count_q, v_count_d;
    logic       last_line;

    assign last_line = (v_count_q == 10'(V_TOTAL - 1));

    always_comb begin
        v_count_d = v_count_q;
        if (enable_i) begin
            v_count_d = last_line ? '0 : v_count_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_count_q <= '0;
        end else begin
            v_count_q <= v_count_d;
        end
    end

    // Decodes use the pre-increment count so they line up with the line-end strobe.
    assign v_count_o    = v_count_q;
    assign vbl_start_o  = enable_i && (v_count_q == 10'(V_VISIBLE - 1));
    assign vbl_end_o    = enable_i && last_line;
    assign frame_wrap_o = enable_i && last_line;

endmodule

// File: rtl/vga_frame_controller.sv
// Registered VGA sync/video/coordinate generation and per-frame game-update handshake.
module vga_frame_controller
    import vga_timing_pkg::*;
(
    input  logic                   clk_25MHz,
    input  logic                   reset_n,
    vga_frame_controller_if.slave  bus
);

    logic [9:0]  v_count;
    logic        vbl_start, vbl_end, frame_wrap;
    logic        h_in_sync, v_in_sync, visible;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        frame_start_q;
    logic [15:0] frame_count_q, frame_count_d;
    upd_state_e  state_q;
    logic        update_req_q;
    logic        overrun_q;
    logic        overrun_set;

    vga_vertical_counter u_vcount (
        .clk_i        (clk_25MHz),
        .rst_ni       (reset_n),
        .enable_i     (bus.enable_V_Counter),
        .v_count_o    (v_count),
        .vbl_start_o  (vbl_start),
        .vbl_end_o    (vbl_end),
        .frame_wrap_o (frame_wrap)
    );

    // H >= H_TOTAL fails every window test, so illegal counts fall into blanking.
    assign h_in_sync = (bus.H_Count_Value >= 16'(H_SYNC_START)) &&
                       (bus.H_Count_Value <  16'(H_SYNC_END));
    assign v_in_sync = (v_count >= 10'(V_SYNC_START)) && (v_count < 10'(V_SYNC_END));
    assign visible   = (bus.H_Count_Value < 16'(H_VISIBLE)) && (v_count < 10'(V_VISIBLE));

    always_comb begin
        hsync_d       = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d       = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_d    = visible;
        pixel_x_d     = visible ? bus.H_Count_Value[9:0] : '0;
        pixel_y_d     = visible ? v_count : '0;
        frame_count_d = frame_wrap ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_wrap;
            frame_count_q <= frame_count_d;
        end
    end

    // An ack arriving on the vbl_end clock still counts as in time.
    assign overrun_set = (state_q == StReq) && vbl_end && !bus.update_ack;

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            update_req_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (vbl_start) begin
                        state_q      <= StReq;
                        update_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus.update_ack) begin
                        state_q      <= vbl_end ? StIdle : StDone;
                        update_req_q <= 1'b0;
                    end else if (vbl_end) begin
                        state_q      <= StIdle;
                        update_req_q <= 1'b0;
                    end
                end
                StDone: begin
                    if (vbl_end) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    update_req_q <= 1'b0;
                end
            endcase

            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.video_on    = video_on_q;
    assign bus.pixel_x     = pixel_x_q;
    assign bus.pixel_y     = pixel_y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_count = frame_count_q;
    assign bus.update_req  = update_req_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_vga_frame_controller.sv
// Directed bench for vga_frame_controller; lines are often compressed to one clock.
module tb_vga_frame_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    vga_frame_controller_if vif ();

    vga_frame_controller dut (
        .clk_25MHz (clk),
        .reset_n   (rst_n),
        .bus       (vif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int v_m   = 0;   // expected v_count register
    int ph, pv;      // H and v_count that produced the outputs now visible

    task automatic step(input int h, input bit en);
        vif.H_Count_Value    = 16'(h);
        vif.enable_V_Counter = en;
        @(posedge clk);
        #1;
        ph = h;
        pv = v_m;
        if (en) v_m = (v_m == 524) ? 0 : v_m + 1;
    endtask

    // One-clock lines: H=0 with the line-end strobe every clock.
    task automatic fast_to(input int target);
        while (v_m != target) step(0, 1'b1);
    endtask

    task automatic test_reset();
        vif.H_Count_Value = '0; vif.enable_V_Counter = 1'b0;
        vif.update_ack = 1'b0;  vif.overrun_clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (vif.hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync: got %b want 1", vif.hsync); end
        n_cmp++; if (vif.vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b want 1", vif.vsync); end
        n_cmp++; if (vif.video_on !== 1'b0) begin n_bad++; $display("FAIL reset_video_on: got %b want 0", vif.video_on); end
        n_cmp++; if (vif.pixel_x !== 10'd0 || vif.pixel_y !== 10'd0) begin n_bad++; $display("FAIL reset_pixel: got %0d,%0d want 0,0", vif.pixel_x, vif.pixel_y); end
        n_cmp++; if (vif.frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start: got %b want 0", vif.frame_start); end
        n_cmp++; if (vif.update_req !== 1'b0) begin n_bad++; $display("FAIL reset_update_req: got %b want 0", vif.update_req); end
        n_cmp++; if (vif.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", vif.overrun); end
        n_cmp++; if (vif.frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", vif.frame_count); end
        @(negedge clk);
        rst_n = 1'b1;
        v_m = 0;
    endtask

    task automatic test_sync_video();
        int hs_low, vid, vs_low, vs_first, rows, fs, bad_px;
        for (int line = 0; line < 2; line++) begin
            hs_low = 0; vid = 0; bad_px = 0;
            for (int h = 0; h < 800; h++) begin
                step(h, h == 0);
                if (vif.hsync === 1'b0) hs_low++;
                if (vif.video_on === 1'b1) vid++;
                if (h == 100 && (vif.pixel_x !== 10'd100 || vif.pixel_y !== 10'(pv))) bad_px++;
            end
            n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL hsync_low_clocks: got %0d want 96", hs_low); end
            n_cmp++; if (vid != 640) begin n_bad++; $display("FAIL video_on_per_line: got %0d want 640", vid); end
            n_cmp++; if (bad_px != 0) begin n_bad++; $display("FAIL pixel_at_h100: got %0d bad want 0", bad_px); end
        end
        vs_low = 0; vs_first = -1; rows = 0; fs = 0;
        for (int i = 0; i < 525; i++) begin
            step(0, 1'b1);
            if (vif.vsync === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = pv; end
            if (vif.video_on === 1'b1) rows++;
            if (vif.frame_start === 1'b1) fs++;
        end
        n_cmp++; if (vs_low != 2) begin n_bad++; $display("FAIL vsync_low_lines: got %0d want 2", vs_low); end
        n_cmp++; if (vs_first != 490) begin n_bad++; $display("FAIL vsync_first_line: got %0d want 490", vs_first); end
        n_cmp++; if (rows != 480) begin n_bad++; $display("FAIL video_rows: got %0d want 480", rows); end
        n_cmp++; if (fs != 1) begin n_bad++; $display("FAIL frame_start_per_frame: got %0d want 1", fs); end
    endtask

    task automatic test_pixel_edge();
        fast_to(479);
        step(639, 1'b0);
        n_cmp++; if ({vif.video_on, vif.pixel_x, vif.pixel_y} !== {1'b1, 10'd639, 10'd479}) begin
            n_bad++; $display("FAIL last_pixel: got %b/%0d/%0d want 1/639/479", vif.video_on, vif.pixel_x, vif.pixel_y); end
        step(640, 1'b0);
        n_cmp++; if ({vif.video_on, vif.pixel_x, vif.pixel_y} !== {1'b0, 10'd0, 10'd0}) begin
            n_bad++; $display("FAIL first_blank: got %b/%0d/%0d want 0/0/0", vif.video_on, vif.pixel_x, vif.pixel_y); end
        step(800, 1'b0);
        n_cmp++; if ({vif.video_on, vif.hsync} !== 2'b01) begin
            n_bad++; $display("FAIL illegal_h: got video %b hsync %b want 0 1", vif.video_on, vif.hsync); end
        step(700, 1'b0);
        n_cmp++; if (vif.hsync !== 1'b0) begin n_bad++; $display("FAIL hsync_mid_pulse: got %b want 0", vif.hsync); end
    endtask

    task automatic test_update_ack();
        int req_hi, extra;
        vif.overrun_clr = 1'b1; step(5, 1'b0); vif.overrun_clr = 1'b0;
        n_cmp++; if (vif.overrun !== 1'b0) begin n_bad++; $display("FAIL clr_before_ack: got %b want 0", vif.overrun); end
        step(0, 1'b1);  // v_count 479 -> vbl_start
        req_hi = (vif.update_req === 1'b1) ? 1 : 0;
        for (int i = 2; i <= 100; i++) begin
            step(i, 1'b0);
            if (vif.update_req === 1'b1) req_hi++;
        end
        vif.update_ack = 1'b1; step(101, 1'b0); vif.update_ack = 1'b0;
        n_cmp++; if (req_hi != 100) begin n_bad++; $display("FAIL req_high_clocks: got %0d want 100", req_hi); end
        n_cmp++; if (vif.update_req !== 1'b0) begin n_bad++; $display("FAIL req_after_ack: got %b want 0", vif.update_req); end
        extra = 0;
        while (v_m != 524) begin step(0, 1'b1); if (vif.update_req === 1'b1) extra++; end
        step(0, 1'b1);
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL req_in_done: got %0d want 0", extra); end
        n_cmp++; if ({vif.frame_start, vif.overrun} !== 2'b10) begin
            n_bad++; $display("FAIL acked_vbl_end: got fs %b ovr %b want 1 0", vif.frame_start, vif.overrun); end
    endtask

    task automatic test_overrun();
        fast_to(479); step(0, 1'b1);
        fast_to(524);
        n_cmp++; if (vif.update_req !== 1'b1) begin n_bad++; $display("FAIL req_held_vblank: got %b want 1", vif.update_req); end
        step(0, 1'b1);
        n_cmp++; if ({vif.update_req, vif.overrun} !== 2'b01) begin
            n_bad++; $display("FAIL overrun_set: got req %b ovr %b want 0 1", vif.update_req, vif.overrun); end
        vif.overrun_clr = 1'b1; step(3, 1'b0); vif.overrun_clr = 1'b0;
        n_cmp++; if (vif.overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clr: got %b want 0", vif.overrun); end
        fast_to(479); step(0, 1'b1);
        fast_to(524);
        vif.overrun_clr = 1'b1; step(0, 1'b1); vif.overrun_clr = 1'b0;
        n_cmp++; if (vif.overrun !== 1'b1) begin n_bad++; $display("FAIL set_beats_clr: got %b want 1", vif.overrun); end
        vif.overrun_clr = 1'b1; step(3, 1'b0); vif.overrun_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        int reqs;
        logic prev;
        fast_to(479); step(0, 1'b1);
        fast_to(524);
        vif.update_ack = 1'b1; step(0, 1'b1); vif.update_ack = 1'b0;
        n_cmp++; if ({vif.update_req, vif.overrun} !== 2'b00) begin
            n_bad++; $display("FAIL ack_at_vbl_end: got req %b ovr %b want 0 0", vif.update_req, vif.overrun); end
        reqs = 0; prev = 1'b0;
        vif.update_ack = 1'b1;
        for (int i = 0; i < 3 * 525; i++) begin
            step(0, 1'b1);
            if (vif.update_req === 1'b1 && !prev) reqs++;
            prev = vif.update_req;
        end
        vif.update_ack = 1'b0;
        n_cmp++; if (reqs != 3) begin n_bad++; $display("FAIL reqs_three_frames: got %0d want 3", reqs); end
        n_cmp++; if (vif.overrun !== 1'b0) begin n_bad++; $display("FAIL ack_held_overrun: got %b want 0", vif.overrun); end
    endtask

    task automatic test_reset_midframe();
        logic [41:0] got;
        int fs_at, fc_at, req_at;
        fast_to(199);
        for (int h = 0; h < 300; h++) step(h, h == 0);
        #7;
        rst_n = 1'b0;
        #1;
        got = {vif.hsync, vif.vsync, vif.video_on, vif.pixel_x, vif.pixel_y,
               vif.frame_start, vif.update_req, vif.overrun, vif.frame_count};
        n_cmp++; if (got !== {3'b110, 20'd0, 3'b000, 16'd0}) begin
            n_bad++; $display("FAIL midline_reset_outputs: got %h want %h", got, {3'b110, 20'd0, 3'b000, 16'd0}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        v_m = 0;
        fs_at = -1; fc_at = -1; req_at = -1;
        for (int i = 0; i < 600; i++) begin
            step(0, 1'b1);
            if (vif.frame_start === 1'b1 && fs_at < 0) begin fs_at = i; fc_at = int'(vif.frame_count); end
            if (vif.update_req === 1'b1 && req_at < 0) req_at = i;
        end
        n_cmp++; if (fs_at != 524) begin n_bad++; $display("FAIL frame_start_after_reset: got step %0d want 524", fs_at); end
        n_cmp++; if (fc_at != 1) begin n_bad++; $display("FAIL frame_count_after_reset: got %0d want 1", fc_at); end
        n_cmp++; if (req_at != 479) begin n_bad++; $display("FAIL first_req_after_reset: got step %0d want 479", req_at); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sync_video();
        test_pixel_edge();
        test_update_ack();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
